// File: rtl/sw_debounce_if.sv
// Switch debouncer signal bundle: raw bouncing switch inputs and the
// debounced levels/strobes that feed the 4-bit counter.
interface sw_debounce_if;
  logic Mode_raw;
  logic SW_raw;
  logic Mode;
  logic SW;
  logic Mode_pulse;
  logic SW_pulse;

  modport master (
    output Mode_raw,
    output SW_raw,
    input  Mode,
    input  SW,
    input  Mode_pulse,
    input  SW_pulse
  );

  modport slave (
    input  Mode_raw,
    input  SW_raw,
    output Mode,
    output SW,
    output Mode_pulse,
    output SW_pulse
  );
endinterface

// File: rtl/sw_debounce.sv
// Two-channel switch debouncer (Mode, SW): 2-flop sync, 4-state FSM with stability counter.
// Optional macro SW_DEBOUNCE_TOGGLE_EN turns the Mode output into a press-toggled register.
module sw_debounce #(
  parameter int DB_CYCLES = 500000,
  parameter int CNT_W     = 20
) (
  input  logic         clk_50M,
  input  logic         Reset,
  sw_debounce_if.slave dbif
);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Channel 1 is Mode, channel 0 is SW
  logic [1:0] raw_s;
  logic [1:0] level_s;
  logic [1:0] pulse_s;

  assign raw_s = {dbif.Mode_raw, dbif.SW_raw};

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic             sync1_r;
    logic             sync2_r;
    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             level_r;
    logic             pulse_r;
    logic             level_next_s;
    logic             pulse_next_s;

    // Two-flop synchronizer for the asynchronous raw switch
    always_ff @(posedge clk_50M or negedge Reset) begin
      if (!Reset) begin
        sync1_r <= 1'b0;
        sync2_r <= 1'b0;
      end else begin
        sync1_r <= raw_s[ch];
        sync2_r <= sync1_r;
      end
    end

    // State, counter and registered level/strobe
    always_ff @(posedge clk_50M or negedge Reset) begin
      if (!Reset) begin
        state_r <= IDLE_LO;
        cnt_r   <= CNT_ZERO;
        level_r <= 1'b0;
        pulse_r <= 1'b0;
      end else begin
        state_r <= state_next_s;
        cnt_r   <= cnt_next_s;
        level_r <= level_next_s;
        pulse_r <= pulse_next_s;
      end
    end

    // Next-state and counter logic; the counter clears on every state change
    always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      case (state_r)
        IDLE_LO: begin
          if (sync2_r) begin
            state_next_s = WAIT_HI;
            cnt_next_s   = CNT_ZERO;
          end else begin
            state_next_s = IDLE_LO;
          end
        end
        WAIT_HI: begin
          if (!sync2_r) begin
            state_next_s = IDLE_LO;
            cnt_next_s   = CNT_ZERO;
          end else if (cnt_r == CNT_LAST) begin
            state_next_s = IDLE_HI;
            cnt_next_s   = CNT_ZERO;
          end else begin
            cnt_next_s   = cnt_r + CNT_ONE;
          end
        end
        IDLE_HI: begin
          if (!sync2_r) begin
            state_next_s = WAIT_LO;
            cnt_next_s   = CNT_ZERO;
          end else begin
            state_next_s = IDLE_HI;
          end
        end
        WAIT_LO: begin
          if (sync2_r) begin
            state_next_s = IDLE_HI;
            cnt_next_s   = CNT_ZERO;
          end else if (cnt_r == CNT_LAST) begin
            state_next_s = IDLE_LO;
            cnt_next_s   = CNT_ZERO;
          end else begin
            cnt_next_s   = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_next_s = IDLE_LO;
          cnt_next_s   = CNT_ZERO;
        end
      endcase
    end

    // Level registered from the next state so it changes together with the FSM
    always_comb begin
      level_next_s = (state_next_s == IDLE_HI) || (state_next_s == WAIT_LO);
      pulse_next_s = (state_r == WAIT_HI) && (state_next_s == IDLE_HI);
    end

    assign level_s[ch] = level_r;
    assign pulse_s[ch] = pulse_r;
  end

  assign dbif.SW         = level_s[0];
  assign dbif.SW_pulse   = pulse_s[0];
  assign dbif.Mode_pulse = pulse_s[1];

`ifdef SW_DEBOUNCE_TOGGLE_EN
  logic mode_tog_r;

  // Mode flips one cycle after each accepted Mode press
  always_ff @(posedge clk_50M or negedge Reset) begin
    if (!Reset) begin
      mode_tog_r <= 1'b0;
    end else begin
      mode_tog_r <= mode_tog_r ^ pulse_s[1];
    end
  end

  assign dbif.Mode = mode_tog_r;
`else
  assign dbif.Mode = level_s[1];
`endif

endmodule
